// File: rtl/cfg_reg_arbiter_pkg.sv
// Shared definitions for the configuration register arbiter: FSM state
// encoding, register count and the fixed register address map.
package cfg_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  localparam int NUM_REGS = 5;

  localparam int ADDR_EN_OUT_LO = 0;
  localparam int ADDR_EN_OUT_HI = 1;
  localparam int ADDR_EN_PWM_LO = 2;
  localparam int ADDR_EN_PWM_HI = 3;
  localparam int ADDR_PWM_DUTY  = 4;

  // Callers zero-extend the full address so no upper bits are ever dropped
  // before the comparison (address 8 must not alias onto register 0).
  function automatic logic addr_in_range(input logic [31:0] addr, input int limit);
    return addr < 32'(limit);
  endfunction

endpackage

// File: rtl/cfg_reg_arbiter_rr_arb2.sv
// Two-way round-robin selector. Keeps the last-granted pointer and picks the
// requester that did not win last time when both are asking.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       update_id,
  output logic       gnt_valid,
  output logic       gnt_id
);

  import cfg_reg_arbiter_pkg::*;

  logic last_reg;

  // Last-granted pointer; reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= 1'b1;
    end else if (update) begin
      last_reg <= update_id;
    end
  end

  // A lone requester always wins; on contention the one not granted last wins.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    if (req[0] && req[1]) begin
      gnt_id = ~last_reg;
    end else begin
      gnt_id = req[1];
    end
  end

endmodule

// File: rtl/cfg_reg_arbiter.sv
// Configuration register write port shared by two requesters (SPI decoder and
// on-chip sequencer). A grant runs IDLE -> WRITE -> ACK, so every accepted
// write completes in three cycles and grants are always separated by IDLE.
module cfg_reg_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [7:0]        en_reg_out_7_0,
  output logic [7:0]        en_reg_out_15_8,
  output logic [7:0]        en_reg_pwm_7_0,
  output logic [7:0]        en_reg_pwm_15_8,
  output logic [7:0]        pwm_duty_cycle,
  output logic              grant_id,
  output logic              busy,
  output logic              wr_err
);

  import cfg_reg_arbiter_pkg::*;

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic              grant_id_reg;
  logic              busy_reg;
  logic              wr_err_reg;
  logic              ready0_reg;
  logic              ready1_reg;

  logic              arb_valid;
  logic              arb_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_in_range;

  logic [DATA_W-1:0] cfg_reg [NUM_REGS];

  // The pointer advances only when the ACK completes, so an aborted
  // transaction (reset mid-flight) never counts as a grant.
  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       ({req1_valid, req0_valid}),
    .update    (state_reg == ST_ACK),
    .update_id (grant_id_reg),
    .gnt_valid (arb_valid),
    .gnt_id    (arb_id)
  );

  // Mux the winning requester's request for capture into the holding registers.
  always_comb begin
    sel_addr     = arb_id ? req1_addr : req0_addr;
    sel_data     = arb_id ? req1_data : req0_data;
    sel_in_range = addr_in_range(32'(sel_addr), NUM_REGS);
  end

  // Main FSM; busy, wr_err, ready and grant_id are all driven from registers.
  // wr_err is decided at grant time so it lands exactly on the WRITE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      data_reg     <= '0;
      grant_id_reg <= 1'b0;
      busy_reg     <= 1'b0;
      wr_err_reg   <= 1'b0;
      ready0_reg   <= 1'b0;
      ready1_reg   <= 1'b0;
    end else begin
      wr_err_reg <= 1'b0;
      ready0_reg <= 1'b0;
      ready1_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (arb_valid) begin
            state_reg    <= ST_WRITE;
            grant_id_reg <= arb_id;
            addr_reg     <= sel_addr;
            data_reg     <= sel_data;
            busy_reg     <= 1'b1;
            wr_err_reg   <= ~sel_in_range;
          end else begin
            busy_reg <= 1'b0;
          end
        end
        ST_WRITE: begin
          state_reg  <= ST_ACK;
          busy_reg   <= 1'b1;
          ready0_reg <= ~grant_id_reg;
          ready1_reg <= grant_id_reg;
        end
        ST_ACK: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // One register per address; each compares the full latched address so an
  // out-of-range write matches no register and everything holds.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cfg
      // Update this register only in WRITE when it is the addressed one.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cfg_reg[gi] <= '0;
        end else if (state_reg == ST_WRITE && addr_reg == ADDR_W'(gi)) begin
          cfg_reg[gi] <= data_reg;
        end
      end
    end
  endgenerate

  assign en_reg_out_7_0  = cfg_reg[ADDR_EN_OUT_LO][7:0];
  assign en_reg_out_15_8 = cfg_reg[ADDR_EN_OUT_HI][7:0];
  assign en_reg_pwm_7_0  = cfg_reg[ADDR_EN_PWM_LO][7:0];
  assign en_reg_pwm_15_8 = cfg_reg[ADDR_EN_PWM_HI][7:0];
  assign pwm_duty_cycle  = cfg_reg[ADDR_PWM_DUTY][7:0];

  assign grant_id   = grant_id_reg;
  assign busy       = busy_reg;
  assign wr_err     = wr_err_reg;
  assign req0_ready = ready0_reg;
  assign req1_ready = ready1_reg;

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// Bench for cfg_reg_arbiter: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_cfg_reg_arbiter;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int NREG   = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0_valid = 1'b0;
  logic [ADDR_W-1:0] req0_addr = '0;
  logic [DATA_W-1:0] req0_data = '0;
  logic              req0_ready;
  logic              req1_valid = 1'b0;
  logic [ADDR_W-1:0] req1_addr = '0;
  logic [DATA_W-1:0] req1_data = '0;
  logic              req1_ready;
  logic [7:0]        en_reg_out_7_0;
  logic [7:0]        en_reg_out_15_8;
  logic [7:0]        en_reg_pwm_7_0;
  logic [7:0]        en_reg_pwm_15_8;
  logic [7:0]        pwm_duty_cycle;
  logic              grant_id;
  logic              busy;
  logic              wr_err;

  always #5 clk = ~clk;

  cfg_reg_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NREG)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req0_valid      (req0_valid),
    .req0_addr       (req0_addr),
    .req0_data       (req0_data),
    .req0_ready      (req0_ready),
    .req1_valid      (req1_valid),
    .req1_addr       (req1_addr),
    .req1_data       (req1_data),
    .req1_ready      (req1_ready),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .grant_id        (grant_id),
    .busy            (busy),
    .wr_err          (wr_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a transaction granted on cycle g shows busy on g+1..g+2,
  // wr_err on g+1, ready and the register update on g+2; next grant >= g+3.
  int          cyc = 0;
  int          free_cyc = 0;
  bit          txn_active = 0;
  int          txn_g = 0;
  int          txn_id = 0;
  int          txn_addr = 0;
  logic [7:0]  txn_data = '0;
  int          last_id = 1;
  int          txn_num = 0;
  logic [7:0]  mdl_regs [NREG];

  // Requester agents
  bit          pend [2];
  bit          gnted [2];
  logic [6:0]  ra [2];
  logic [7:0]  rd [2];
  logic        drv_v [2];
  logic [6:0]  drv_a [2];
  logic [7:0]  drv_d [2];
  bit          rnd_mode = 0;
  bit          renew_mode = 0;
  bit          drop_mode = 0;
  bit          scramble = 0;

  // Observations
  int          rdy_cnt [2];
  int          err_cnt = 0;
  int          obs_gnt [$];
  logic        prev_busy = 1'b0;

  function automatic logic [7:0] get_reg(input int i);
    case (i)
      0:       return en_reg_out_7_0;
      1:       return en_reg_out_15_8;
      2:       return en_reg_pwm_7_0;
      3:       return en_reg_pwm_15_8;
      default: return pwm_duty_cycle;
    endcase
  endfunction

  task automatic apply_inputs();
    req0_valid = drv_v[0];
    req0_addr  = drv_a[0];
    req0_data  = drv_d[0];
    req1_valid = drv_v[1];
    req1_addr  = drv_a[1];
    req1_data  = drv_d[1];
  endtask

  task automatic clear_obs();
    rdy_cnt[0] = 0;
    rdy_cnt[1] = 0;
    err_cnt = 0;
    obs_gnt.delete();
  endtask

  task automatic set_req(input int k, input logic [6:0] a, input logic [7:0] d);
    pend[k] = 1;
    ra[k] = a;
    rd[k] = d;
  endtask

  task automatic new_req(input int k);
    pend[k] = 1;
    if ($urandom % 4 == 0) ra[k] = 7'($urandom_range(127, 5));
    else                   ra[k] = 7'($urandom % 5);
    rd[k] = 8'($urandom);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rdy0", 32'(req0_ready), 32'd0);
    check_eq("rst_rdy1", 32'(req1_ready), 32'd0);
    check_eq("rst_wr_err", 32'(wr_err), 32'd0);
    check_eq("rst_grant_id", 32'(grant_id), 32'd0);
    for (int i = 0; i < NREG; i++) check_eq($sformatf("rst_reg%0d", i), 32'(get_reg(i)), 32'd0);
    for (int i = 0; i < NREG; i++) mdl_regs[i] = 8'h00;
    txn_active = 0;
    free_cyc = 0;
    last_id = 1;
    for (int k = 0; k < 2; k++) begin
      pend[k] = 0;
      gnted[k] = 0;
      drv_v[k] = 1'b0;
      drv_a[k] = '0;
      drv_d[k] = '0;
    end
    apply_inputs();
    @(posedge clk);
    #1;
    cyc++;
    check_eq("rst_hold_busy", 32'(busy), 32'd0);
    #2;
    rst_n = 1'b1;
    prev_busy = 1'b0;
  endtask

  task automatic step();
    bit wr_cyc;
    bit ack_cyc;
    int w;
    @(posedge clk);
    #1;
    cyc++;
    wr_cyc  = txn_active && (cyc == txn_g + 1);
    ack_cyc = txn_active && (cyc == txn_g + 2);
    if (ack_cyc && txn_addr < NREG) mdl_regs[txn_addr] = txn_data;
    check_eq("busy", 32'(busy), 32'(wr_cyc || ack_cyc));
    if (wr_cyc || ack_cyc) check_eq("grant_id", 32'(grant_id), 32'(txn_id));
    check_eq("wr_err", 32'(wr_err), 32'(wr_cyc && txn_addr >= NREG));
    check_eq("req0_ready", 32'(req0_ready), 32'(ack_cyc && txn_id == 0));
    check_eq("req1_ready", 32'(req1_ready), 32'(ack_cyc && txn_id == 1));
    for (int i = 0; i < NREG; i++) check_eq($sformatf("reg%0d", i), 32'(get_reg(i)), 32'(mdl_regs[i]));
    if (req0_ready) rdy_cnt[0]++;
    if (req1_ready) rdy_cnt[1]++;
    if (wr_err) err_cnt++;
    if (busy && !prev_busy) obs_gnt.push_back(int'(grant_id));
    prev_busy = busy;

    if (ack_cyc) begin
      pend[txn_id] = 0;
      gnted[txn_id] = 0;
      txn_active = 0;
    end

    for (int k = 0; k < 2; k++) begin
      if (gnted[k]) begin
        // After the grant the requester may drop valid and change addr/data.
        drv_v[k] = drop_mode ? 1'b0 : (scramble ? 1'($urandom % 2) : 1'b1);
        drv_a[k] = (scramble || drop_mode) ? 7'($urandom) : ra[k];
        drv_d[k] = (scramble || drop_mode) ? 8'($urandom) : rd[k];
      end else begin
        if (!pend[k] && (renew_mode || (rnd_mode && $urandom % 3 == 0))) new_req(k);
        if (pend[k]) begin
          drv_v[k] = 1'b1;
          drv_a[k] = ra[k];
          drv_d[k] = rd[k];
        end else begin
          drv_v[k] = 1'b0;
          drv_a[k] = 7'($urandom);
          drv_d[k] = 8'($urandom);
        end
      end
    end
    apply_inputs();

    if (cyc >= free_cyc && (drv_v[0] || drv_v[1])) begin
      if (drv_v[0] && drv_v[1]) w = 1 - last_id;
      else                      w = drv_v[1] ? 1 : 0;
      last_id    = w;
      txn_active = 1;
      txn_g      = cyc;
      txn_id     = w;
      txn_addr   = int'(ra[w]);
      txn_data   = rd[w];
      gnted[w]   = 1;
      free_cyc   = cyc + 3;
      txn_num++;
      $display("txn %0d cyc %0d req%0d addr %0d data %02h", txn_num, cyc, w, txn_addr, txn_data);
    end
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) mdl_regs[i] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      pend[k] = 0;
      gnted[k] = 0;
      drv_v[k] = 1'b0;
      drv_a[k] = '0;
      drv_d[k] = '0;
    end
    @(posedge clk);
    #1;
    do_reset();

    // Single requester write to address 0
    clear_obs();
    set_req(0, 7'd0, 8'hA5);
    repeat (6) step();
    check_eq("t1_out_lo", 32'(en_reg_out_7_0), 32'h A5);
    check_eq("t1_out_hi", 32'(en_reg_out_15_8), 32'h00);
    check_eq("t1_duty", 32'(pwm_duty_cycle), 32'h00);
    check_eq("t1_rdy0_cnt", 32'(rdy_cnt[0]), 32'd1);
    check_eq("t1_rdy1_cnt", 32'(rdy_cnt[1]), 32'd0);

    // Contention straight out of reset: requester 0 first
    do_reset();
    clear_obs();
    set_req(0, 7'd2, 8'h0F);
    set_req(1, 7'd4, 8'h80);
    repeat (9) step();
    check_eq("t2_ngrants", 32'(obs_gnt.size()), 32'd2);
    if (obs_gnt.size() >= 2) begin
      check_eq("t2_first", 32'(obs_gnt[0]), 32'd0);
      check_eq("t2_second", 32'(obs_gnt[1]), 32'd1);
    end
    check_eq("t2_pwm_lo", 32'(en_reg_pwm_7_0), 32'h0F);
    check_eq("t2_duty", 32'(pwm_duty_cycle), 32'h80);

    // Out-of-range address 8 must not alias onto register 0
    clear_obs();
    set_req(1, 7'd8, 8'hFF);
    repeat (6) step();
    check_eq("t3_err_cnt", 32'(err_cnt), 32'd1);
    check_eq("t3_rdy1_cnt", 32'(rdy_cnt[1]), 32'd1);
    check_eq("t3_out_lo", 32'(en_reg_out_7_0), 32'h00);
    check_eq("t3_pwm_lo", 32'(en_reg_pwm_7_0), 32'h0F);

    // Valid dropped and addr/data changed right after the grant
    clear_obs();
    drop_mode = 1;
    set_req(0, 7'd1, 8'h3C);
    repeat (6) step();
    drop_mode = 0;
    check_eq("t4_out_hi", 32'(en_reg_out_15_8), 32'h3C);
    check_eq("t4_rdy0_cnt", 32'(rdy_cnt[0]), 32'd1);

    // Reset asserted during WRITE aborts the transaction
    do_reset();
    clear_obs();
    set_req(1, 7'd3, 8'h55);
    for (int i = 0; i < 10 && !(txn_active && cyc == txn_g + 1); i++) step();
    check_eq("t5_busy_in_write", 32'(busy), 32'd1);
    do_reset();
    repeat (5) step();
    check_eq("t5_pwm_hi", 32'(en_reg_pwm_15_8), 32'h00);
    check_eq("t5_rdy1_cnt", 32'(rdy_cnt[1]), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);

    // Both requesters continuously valid: grants must alternate
    do_reset();
    clear_obs();
    renew_mode = 1;
    repeat (18) step();
    renew_mode = 0;
    repeat (12) step();
    check_eq("t6_ngrants_ge6", 32'(obs_gnt.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < obs_gnt.size(); i++)
      check_eq($sformatf("t6_grant%0d", i), 32'(obs_gnt[i]), 32'(i % 2));

    // Randomized traffic with a reset dropped in mid-stream
    rnd_mode = 1;
    scramble = 1;
    repeat (300) step();
    do_reset();
    repeat (200) step();
    rnd_mode = 0;
    repeat (12) step();
    scramble = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cfg_reg_arbiter.md
CFG_REG_ARBITER -- requirements
Module: cfg_reg_arbiter

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- ADDR_W, 7, requester address width.
- DATA_W, 8, register data width.
- NUM_REGS, 5, number of writable configuration registers (addresses 0..NUM_REGS-1).

REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk, input, 1, single clock for all logic.
- rst_n, input, 1, reset; asynchronous, active-low.
- req0_valid, input, 1, requester 0 (SPI decoder) write request.
- req0_addr, input, ADDR_W, requester 0 target address.
- req0_data, input, DATA_W, requester 0 write data.
- req0_ready, output, 1, requester 0 write accepted and complete.
- req1_valid, input, 1, requester 1 (on-chip sequencer) write request.
- req1_addr, input, ADDR_W, requester 1 target address.
- req1_data, input, DATA_W, requester 1 write data.
- req1_ready, output, 1, requester 1 write accepted and complete.
- en_reg_out_7_0, output, 8, output enables for bits 7:0 (address 0).
- en_reg_out_15_8, output, 8, output enables for bits 15:8 (address 1).
- en_reg_pwm_7_0, output, 8, PWM select for bits 7:0 (address 2).
- en_reg_pwm_15_8, output, 8, PWM select for bits 15:8 (address 3).
- pwm_duty_cycle, output, 8, PWM duty value (address 4).
- grant_id, output, 1, index of the requester currently owning the write port; valid when busy=1.
- busy, output, 1, high in any state other than IDLE.
- wr_err, output, 1, one-cycle pulse when a granted write targets address >= NUM_REGS.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, WRITE, ACK.
REQ-004 In IDLE, if any reqN_valid=1, the block SHALL grant one requester, latch its addr/data into holding registers, and go to WRITE next cycle. If neither is valid, it SHALL stay in IDLE.
REQ-005 Arbitration SHALL be round-robin. When both requests are valid, the requester not granted last wins. A single valid requester SHALL always win, regardless of history.
REQ-006 In WRITE, if the latched address is < NUM_REGS, only the addressed register SHALL be updated; all other registers SHALL hold their value. Otherwise no register changes and wr_err SHALL pulse high for exactly this cycle. The next state SHALL be ACK.
REQ-007 In ACK, the block SHALL drive the granted requester's reqN_ready=1 for exactly one cycle, record it as last granted, and return to IDLE.
REQ-008 Timing: valid sampled in IDLE at cycle N -> register value visible at cycle N+2 -> ready high during cycle N+2. Back-to-back grants SHALL be separated by at least one IDLE cycle.
REQ-009 Handshake rules:
- Requesters hold valid/addr/data until ready.
- Dropping valid after the grant SHALL NOT cancel the write; ready SHALL still pulse.
- Changes to addr/data after the grant SHALL be ignored.
REQ-010 The non-granted requester's ready SHALL remain 0 throughout. Its pending request SHALL be served on the next IDLE evaluation.
REQ-011 Address comparison SHALL use the full ADDR_W bits; no truncation aliasing (e.g. address 8 is an error, not register 0).
REQ-012 ready, wr_err and busy SHALL be registered outputs.

Reset
REQ-013 Asserting rst_n=0 SHALL immediately and asynchronously force:
- state to IDLE;
- all five configuration outputs to 8'h00;
- req0_ready, req1_ready, wr_err, busy and grant_id to 0;
- last-granted pointer to 1, so requester 0 wins the first contention.
REQ-014 Reset during WRITE or ACK SHALL abort the transaction: no ready pulse after release, and the register value is the reset value.

Structure
REQ-015 A shared package SHALL hold the FSM state encoding, NUM_REGS, and the address constants ADDR_EN_OUT_LO=0, ADDR_EN_OUT_HI=1, ADDR_EN_PWM_LO=2, ADDR_EN_PWM_HI=3, ADDR_PWM_DUTY=4.
REQ-016 The round-robin selection SHALL be a sub-module named rr_arb2.

Verification
REQ-017 Req0 only, addr=0, data=8'hA5 -> en_reg_out_7_0=8'hA5 two cycles later; req0_ready pulses once; the other four registers stay 8'h00.
REQ-018 Both valid from reset (req0 addr=2 data=8'h0F; req1 addr=4 data=8'h80) -> req0 served first, then req1; en_reg_pwm_7_0=8'h0F, pwm_duty_cycle=8'h80; grant_id sequence 0 then 1.
REQ-019 Req1 addr=8 data=8'hFF -> wr_err pulses one cycle; all registers unchanged; req1_ready pulses.
REQ-020 Req0 addr=1 data=8'h3C, valid dropped the cycle after grant -> en_reg_out_15_8=8'h3C; req0_ready still pulses.
REQ-021 rst_n asserted in WRITE for req1 addr=3 data=8'h55 -> en_reg_pwm_15_8 stays 8'h00; no ready after release; busy=0.
REQ-022 Both valid held continuously for 6 grants -> grants alternate 0,1,0,1,0,1; no requester starves.
